// File: rtl/alu_cmd_issuer.sv
// Command issuer for a combinational ALU: queues {a,b,sel,tag} commands, drives the ALU,
// holds the inputs for a settle window, captures the result and returns it with the caller tag.
module alu_cmd_issuer #(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [3:0]  cmd_sel,
  input  logic [3:0]  cmd_tag,
  output logic [7:0]  A,
  output logic [7:0]  B,
  output logic [3:0]  ALU_Sel,
  input  logic [7:0]  ALU_Out,
  input  logic        CarryOut,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_result,
  output logic        rsp_carry,
  output logic [3:0]  rsp_sel,
  output logic [3:0]  rsp_tag,
  output logic        busy,
  output logic [15:0] done_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = 24;
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] fifo_head;
  logic          fifo_empty, fifo_full, push, pop;
  logic          capture, rsp_done;

  logic [7:0]    a_reg, b_reg;
  logic [3:0]    sel_reg, tag_reg;
  logic [3:0]    settle_cnt_reg;
  logic          rsp_valid_reg;
  logic [7:0]    rsp_result_reg;
  logic          rsp_carry_reg;
  logic [3:0]    rsp_sel_reg, rsp_tag_reg;
  logic [15:0]   done_cnt_reg;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign fifo_head  = fifo_mem[rd_ptr_reg[AW-1:0]];
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && !fifo_full;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg[AW-1:0]] <= {cmd_a, cmd_b, cmd_sel, cmd_tag};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + {{AW{1'b0}}, 1'b1};
      if (pop)  rd_ptr_reg <= rd_ptr_reg + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    capture    = 1'b0;
    rsp_done   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = DRIVE;
        end
      end
      DRIVE: begin
        if (settle_cnt_reg == 4'd0) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        // Chain straight into the next command when one is waiting.
        if (rsp_ready) begin
          rsp_done = 1'b1;
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = DRIVE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg          <= '0;
      b_reg          <= '0;
      sel_reg        <= '0;
      tag_reg        <= '0;
      settle_cnt_reg <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_result_reg <= '0;
      rsp_carry_reg  <= 1'b0;
      rsp_sel_reg    <= '0;
      rsp_tag_reg    <= '0;
      done_cnt_reg   <= '0;
    end else begin
      if (pop) begin
        {a_reg, b_reg, sel_reg, tag_reg} <= fifo_head;
        settle_cnt_reg <= SETTLE_LOAD;
      end else if (state_reg == DRIVE && settle_cnt_reg != 4'd0) begin
        settle_cnt_reg <= settle_cnt_reg - 4'd1;
      end
      if (capture) begin
        rsp_valid_reg  <= 1'b1;
        rsp_result_reg <= ALU_Out;
        rsp_carry_reg  <= CarryOut;
        rsp_sel_reg    <= sel_reg;
        rsp_tag_reg    <= tag_reg;
      end else if (rsp_done) begin
        rsp_valid_reg  <= 1'b0;
      end
      if (rsp_done) done_cnt_reg <= done_cnt_reg + 16'd1;
    end
  end

  assign A          = a_reg;
  assign B          = b_reg;
  assign ALU_Sel    = sel_reg;
  assign rsp_valid  = rsp_valid_reg;
  assign rsp_result = rsp_result_reg;
  assign rsp_carry  = rsp_carry_reg;
  assign rsp_sel    = rsp_sel_reg;
  assign rsp_tag    = rsp_tag_reg;
  assign done_cnt   = done_cnt_reg;
  assign busy       = (state_reg != IDLE) || !fifo_empty;

endmodule

// File: doc/alu_cmd_issuer.md
ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command FIFO entries (power of 2, 2..16).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 1, cycles ALU inputs are held before capture (legal 1..15).
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port cmd_valid  input  1  command offered.
REQ-007 SHALL have port cmd_ready  output  1  command FIFO can accept.
REQ-008 SHALL have ports cmd_a, cmd_b  input  8 each  command operands.
REQ-009 SHALL have port cmd_sel  input  4  ALU operation code.
REQ-010 SHALL have port cmd_tag  input  4  caller ID, returned with the result.
REQ-011 SHALL have ports A, B  output  8 each  registered operands to the ALU.
REQ-012 SHALL have port ALU_Sel  output  4  registered operation select to the ALU.
REQ-013 SHALL have port ALU_Out  input  8  ALU result.
REQ-014 SHALL have port CarryOut  input  1  ALU carry flag.
REQ-015 SHALL have port rsp_valid  output  1  response available.
REQ-016 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-017 SHALL have ports rsp_result  output  8, rsp_carry  output  1, rsp_sel  output  4, rsp_tag  output  4  captured response fields.
REQ-018 SHALL have port busy  output  1  high when state is not IDLE or the FIFO is non-empty.
REQ-019 SHALL have port done_cnt  output  16  completed responses, wraps 0xFFFF->0x0000.

Function
REQ-020 SHALL accept a command on a rising edge with cmd_valid && cmd_ready, pushing {a,b,sel,tag} into the FIFO.
REQ-021 SHALL drive cmd_ready = !fifo_full, independent of a same-cycle pop (no push when full).
REQ-022 SHALL, on a simultaneous push and pop with the FIFO not full, keep occupancy unchanged and preserve order.
REQ-023 SHALL implement FSM states IDLE, DRIVE, RESP.
REQ-024 SHALL, in IDLE with the FIFO non-empty, pop the head on the next edge, load A/B/ALU_Sel and the tag, and enter DRIVE.
REQ-025 SHALL remain in DRIVE exactly SETTLE_CYCLES cycles (4-bit down-counter).
REQ-026 SHALL, on the final DRIVE edge, register ALU_Out, CarryOut, ALU_Sel and the tag into rsp_* and enter RESP with rsp_valid=1.
REQ-027 SHALL give latency from accept edge (idle, FIFO empty) to rsp_valid high = SETTLE_CYCLES+2 edges.
REQ-028 SHALL hold rsp_valid and all rsp_* stable in RESP until rsp_valid && rsp_ready.
REQ-029 SHALL, on the response handshake edge, increment done_cnt; if the FIFO is non-empty, pop and go directly to DRIVE (no IDLE bubble), otherwise go to IDLE.
REQ-030 SHALL hold A/B/ALU_Sel at their last driven values in IDLE and RESP.
REQ-031 SHALL return responses in command-acceptance order.

Reset
REQ-032 SHALL, on rst assertion at any time, asynchronously force state IDLE, empty FIFO, and zero all outputs except cmd_ready.
REQ-033 SHALL drive cmd_ready=1 during and after reset.
REQ-034 SHALL discard in-flight and queued commands on reset without emitting a response.

Verification
REQ-035 SHALL cover: cmd a=0x0F, b=0x01, sel=0000, tag=3, rsp_ready=1 -> rsp_valid high 3 edges after accept, result=0x10, carry=0, tag=3, done_cnt=1.
REQ-036 SHALL cover: a=0xFF, b=0x01, sel=0000 -> result=0x00, carry=1; a=0x06, b=0x07, sel=0010 -> result=0x2A.
REQ-037 SHALL cover: rsp_ready=0, issue 6 back-to-back commands -> 5 accepted (1 in RESP + 4 in FIFO), cmd_ready=0 on the 6th, then rsp_ready=1 -> tags returned in order with no IDLE gap between responses.
REQ-038 SHALL cover: rst asserted mid-DRIVE with 2 queued commands -> rsp_valid=0, busy=0, cmd_ready=1, A=B=0 immediately, and no responses after release.
REQ-039 SHALL cover: SETTLE_CYCLES=3, ALU_Out changing during DRIVE -> captured value is the one present on the third DRIVE cycle; latency is 5 edges.
REQ-040 SHALL cover: done_cnt preloaded via 65536 completions -> wraps to 0x0000.
